// File: rtl/instruction_fetch.sv
// Fetch stage: issues imem requests from an internal PC mirror, fills the IF/ID
// register, and steers ProgramCounter for sequential advance and redirects.
module instruction_fetch #(
   parameter int unsigned WORD_LEN = 32
) (
   input  logic                clk_i,
   input  logic                reset_i,
   input  logic [WORD_LEN-1:0] pc_i,
   output logic [WORD_LEN-1:0] pc_next_o,
   output logic                pc_enable_o,
   output logic                imem_req_o,
   output logic [WORD_LEN-1:0] imem_addr_o,
   input  logic                imem_ready_i,
   input  logic [WORD_LEN-1:0] imem_rdata_i,
   input  logic                redirect_i,
   input  logic [WORD_LEN-1:0] redirect_target_i,
   input  logic                id_stall_i,
   output logic                id_valid_o,
   output logic [WORD_LEN-1:0] id_instr_o,
   output logic [WORD_LEN-1:0] id_pc_o,
   output logic [WORD_LEN-1:0] id_pc_plus4_o,
   output logic                id_fault_o
);

   localparam logic [WORD_LEN-1:0] STEP = WORD_LEN'(4);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FETCH = 2'd1,
      S_FAULT = 2'd2
   } state_e;

   state_e              state_q;
   logic [WORD_LEN-1:0] req_addr_q;
   logic                fault_done_q;
   logic                id_valid_q;
   logic [WORD_LEN-1:0] id_instr_q;
   logic [WORD_LEN-1:0] id_pc_q;
   logic [WORD_LEN-1:0] id_pc_plus4_q;
   logic                id_fault_q;

   logic [WORD_LEN-1:0] req_addr_plus4;
   logic                req_c;
   logic                xfer_c;
   logic                redirect_c;
   logic                id_free_c;

   assign req_addr_plus4 = req_addr_q + STEP;
   assign id_free_c      = !id_valid_q || !id_stall_i;
   assign redirect_c     = redirect_i && !reset_i;

   // Request is combinational so a redirect or stall withdraws it in the same cycle.
   always_comb begin
      req_c = 1'b0;
      if (!reset_i && (state_q == S_FETCH)) begin
         req_c = !redirect_i && id_free_c;
      end
   end

   assign xfer_c = req_c && imem_ready_i;

   // PC steering: redirect wins over sequential advance.
   always_comb begin
      pc_enable_o = xfer_c || redirect_c;
      pc_next_o   = req_addr_plus4;
      if (redirect_c) begin
         pc_next_o = redirect_target_i;
      end else if (state_q == S_IDLE) begin
         pc_next_o = '0;
      end
   end

   assign imem_req_o    = req_c;
   assign imem_addr_o   = req_addr_q;
   assign id_valid_o    = id_valid_q;
   assign id_instr_o    = id_instr_q;
   assign id_pc_o       = id_pc_q;
   assign id_pc_plus4_o = id_pc_plus4_q;
   assign id_fault_o    = id_fault_q;

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q       <= S_IDLE;
         req_addr_q    <= '0;
         fault_done_q  <= 1'b0;
         id_valid_q    <= 1'b0;
         id_instr_q    <= '0;
         id_pc_q       <= '0;
         id_pc_plus4_q <= '0;
         id_fault_q    <= 1'b0;
      end else if (redirect_i) begin
         req_addr_q   <= redirect_target_i;
         fault_done_q <= 1'b0;
         id_valid_q   <= 1'b0;
         id_fault_q   <= 1'b0;
         state_q      <= (redirect_target_i[1:0] == 2'b00) ? S_FETCH : S_FAULT;
      end else begin
         case (state_q)
            S_IDLE: begin
               req_addr_q   <= pc_i;
               fault_done_q <= 1'b0;
               state_q      <= (pc_i[1:0] == 2'b00) ? S_FETCH : S_FAULT;
            end
            S_FETCH: begin
               if (xfer_c) begin
                  id_valid_q    <= 1'b1;
                  id_instr_q    <= imem_rdata_i;
                  id_pc_q       <= req_addr_q;
                  id_pc_plus4_q <= req_addr_plus4;
                  id_fault_q    <= 1'b0;
                  req_addr_q    <= req_addr_plus4;
               end else if (!id_stall_i) begin
                  id_valid_q <= 1'b0;
               end
            end
            S_FAULT: begin
               // Deliver the fault marker exactly once, then park until redirected.
               if (!fault_done_q && id_free_c) begin
                  id_valid_q    <= 1'b1;
                  id_instr_q    <= '0;
                  id_pc_q       <= req_addr_q;
                  id_pc_plus4_q <= req_addr_plus4;
                  id_fault_q    <= 1'b1;
                  fault_done_q  <= 1'b1;
               end else if (!id_stall_i) begin
                  id_valid_q <= 1'b0;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Fetch stage directly downstream of `ProgramCounter`. It reads the current `PC`, issues instruction-memory requests over a ready/valid handshake, and loads the returned word into the IF/ID pipeline register for decode. It also drives `ProgramCounter`'s `newPC`/`enable` for sequential advance (+4) and for branch/jump redirects from later stages. It supports decode back-pressure, flush-on-redirect and misaligned-fetch faults.

## Interface
- `WORD_LEN`, default 32 (from config.v): address/instruction width.
- `clk`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high.
- `pc`  in  WORD_LEN  current PC from `ProgramCounter`.
- `pc_next`  out  WORD_LEN  to `ProgramCounter.newPC`.
- `pc_enable`  out  1  to `ProgramCounter.enable`.
- `imem_req`  out  1  fetch request valid.
- `imem_addr`  out  WORD_LEN  fetch address.
- `imem_ready`  in  1  memory accepts request; `imem_rdata` valid in the same cycle.
- `imem_rdata`  in  WORD_LEN  instruction word.
- `redirect`  in  1  branch/jump taken (1-cycle pulse from EX).
- `redirect_target`  in  WORD_LEN  new fetch address.
- `id_stall`  in  1  decode cannot accept this cycle.
- `id_valid`  out  1  IF/ID entry valid.
- `id_instr`, `id_pc`, `id_pc_plus4`  out  WORD_LEN  IF/ID contents.
- `id_fault`  out  1  entry is a misaligned-fetch fault.

## Operation
- Internal `req_addr` register mirrors the PC. States: IDLE, FETCH, FAULT.
- Reset: state IDLE, `req_addr`=0. All IF/ID outputs are 0. `imem_req`=0, `pc_enable`=0, `pc_next`=0.
- IDLE: no request. Next cycle: `req_addr`<=`pc`. Go to FETCH, or to FAULT if `pc[1:0]`!=0.
- FETCH:
  - `imem_req` = !`redirect` & (!`id_valid` | !`id_stall`).
  - `imem_addr`=`req_addr`.
- Transfer: `imem_req` & `imem_ready` in the same cycle. The requester may withdraw an untransferred request; memory must not latch on `imem_req` alone.
- On transfer:
  - IF/ID <= {1, `imem_rdata`, `req_addr`, `req_addr`+4, fault 0}.
  - `pc_enable`=1, `pc_next`=`req_addr`+4.
  - `req_addr`+=4. Stay in FETCH.
- No transfer and !`id_stall`: `id_valid`<=0 (entry consumed, bubble).
- No transfer and `id_stall`: IF/ID holds unchanged.
- Redirect (any state, highest priority):
  - `pc_enable`=1, `pc_next`=`redirect_target`, `imem_req`=0.
  - `id_valid`<=0 and `id_fault`<=0, even when `id_stall`=1.
  - `req_addr`<=`redirect_target`.
  - Next state: FETCH if target is aligned, FAULT otherwise.
- FAULT: on entry, when IF/ID is free (!`id_valid` | !`id_stall`), load {1, 0x00000000, `req_addr`, `req_addr`+4, fault 1} once. Then idle with `imem_req`=0 until `redirect`.
- Arithmetic: +4 is modulo 2^WORD_LEN. 0xFFFFFFFC wraps to 0x00000000 with no flag.
- `pc_enable`=0 in every cycle with neither transfer nor redirect. `pc_next` is then `req_addr`+4 (don't-care).

## Timing
- Reset has priority over everything, including a mid-transfer memory response and a pending redirect. Post-reset, the first `imem_req` is asserted in the 2nd cycle after `reset` deasserts.
- Latency: transfer in cycle N gives `id_valid`=1 in N+1. `ProgramCounter.PC` updates at the end of N.
- Throughput: 1 instruction/cycle while `imem_ready`=1 and `id_stall`=0.
- Redirect in cycle N: no transfer in N. The first request to the target is in N+1, and its data reaches IF/ID in N+2 at the earliest.
- Redirect and `imem_ready` in the same cycle: the response is ignored and the PC takes the target.
- `id_stall`=1 with `id_valid`=1: `imem_req`=0 and the PC is frozen. Requests resume in the cycle `id_stall` drops.
- `imem_ready` may arrive in the same cycle as the request.

## Test plan
- Reset, then `pc`=0 and `imem_ready` held 1: `imem_addr` goes 0,4,8,C on consecutive cycles. `id_pc` is 0,4,8 one cycle later, `id_pc_plus4` = `id_pc`+4, and `pc_enable`=1 each cycle.
- Memory waits 3 cycles before `imem_ready`: `imem_req`/`imem_addr`=0x10 held stable, `pc_enable`=0 during the wait, and `id_valid`=1 only in the cycle after ready.
- `id_stall`=1 for 2 cycles with `id_valid`=1 (instr 0x8C010004): IF/ID is unchanged, `imem_req`=0 and the PC is frozen. After release, the next fetch address is the held `id_pc`+4.
- `redirect`=1 to 0x000000A0 while stalled with `imem_ready`=1: `id_valid`=0 next cycle, `pc_next`=0xA0 with `pc_enable`=1, and the next `imem_addr`=0xA0.
- `redirect_target`=0x00000102: next entry has `id_fault`=1, `id_instr`=0, `id_pc`=0x102. Then no `imem_req` until a redirect to 0x100 resumes fetch.
- `reset` asserted mid-stream with `imem_ready`=1: the next cycle shows all outputs 0 and state IDLE. `req_addr`=0xFFFFFFFC wraps, with `pc_next`=0x00000000.
